nand_bus_cycle: RTL and testbench

- NAND pin-level timing engine between the UART command decoder and the NAND pins/tri-state buffer.
- Accepts one bus request at a time: command byte, address byte, data write, or data read.
- Generates the CE/CLE/ALE/WE/RE waveform with parameterised strobe widths, drives the write-data bus and its enable, and captures read data.
- Optionally waits for R/B after the cycle.

---
 rtl/nand_bus_cycle.sv | 232 +++++++++++++++++++++++
 tb/tb_nand_bus_cycle.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_bus_cycle.sv
// NAND pin-level bus cycle engine: CE/CLE/ALE/WE/RE waveform generation,
// write-data drive, read capture and optional ready/busy wait.
// Build option: define NAND_RB_TIMEOUT_EN to bound the R/B wait by RB_TIMEOUT
// cycles; otherwise the engine waits for R/B indefinitely.
module nand_bus_cycle #(
  parameter int T_LOW      = 2,
  parameter int T_HIGH     = 2,
  parameter int T_WB       = 4,
  parameter int RB_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_type,
  input  logic [7:0] req_data,
  input  logic       req_last,
  input  logic       req_wait_rb,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       rb_timeout,
  output logic       ce,
  output logic       cle,
  output logic       ale,
  output logic       we,
  output logic       re,
  output logic [7:0] io_write,
  output logic       io_drive_en,
  input  logic [7:0] io,
  input  logic       rb
);

  if (T_LOW < 1 || T_LOW > 255 || T_HIGH < 1 || T_HIGH > 255 ||
      T_WB < 1 || T_WB > 255 || RB_TIMEOUT < 1 || RB_TIMEOUT > 24'hFFFFFF) begin : g_bad_param
    $error("nand_bus_cycle: timing parameter out of range");
  end

  localparam logic [1:0] TYPE_CMD  = 2'b00;
  localparam logic [1:0] TYPE_ADDR = 2'b01;
  localparam logic [1:0] TYPE_READ = 2'b11;

  localparam logic [7:0] LOW_LAST  = 8'(T_LOW - 1);
  localparam logic [7:0] HIGH_LAST = 8'(T_HIGH - 1);
  localparam logic [7:0] WB_LAST   = 8'(T_WB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOW, S_HIGH, S_WB, S_WAIT_RB, S_TIMEOUT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] type_q, type_d;
  logic       last_q, last_d;
  logic       wait_q, wait_d;
  logic       ce_q, ce_d, cle_q, cle_d, ale_q, ale_d, we_q, we_d, re_q, re_d;
  logic       drive_q, drive_d;
  logic [7:0] io_write_q, io_write_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rb_meta, rb_s;

`ifdef NAND_RB_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(RB_TIMEOUT - 1);
  logic [23:0] tmo_q, tmo_d;
`endif

  // Two-flop synchroniser for the asynchronous ready/busy pin; preset to ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_meta <= 1'b1;
      rb_s    <= 1'b1;
    end else begin
      rb_meta <= rb;
      rb_s    <= rb_meta;
    end
  end

  // Next-state and next pin values; pins are registered so they change on the edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    last_d     = last_q;
    wait_d     = wait_q;
    ce_d       = ce_q;
    cle_d      = cle_q;
    ale_d      = ale_q;
    we_d       = we_q;
    re_d       = re_q;
    drive_d    = drive_q;
    io_write_d = io_write_q;
    rsp_data_d = rsp_data_q;
`ifdef NAND_RB_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_LOW;
          cnt_d   = 8'd0;
          type_d  = req_type;
          last_d  = req_last;
          wait_d  = req_wait_rb;
          ce_d    = 1'b0;
          cle_d   = (req_type == TYPE_CMD);
          ale_d   = (req_type == TYPE_ADDR);
          if (req_type == TYPE_READ) begin
            drive_d = 1'b0;
            re_d    = 1'b0;
          end else begin
            drive_d    = 1'b1;
            io_write_d = req_data;
            we_d       = 1'b0;
          end
        end
      end
      S_LOW: begin
        if (cnt_q == LOW_LAST) begin
          state_d = S_HIGH;
          cnt_d   = 8'd0;
          we_d    = 1'b1;
          re_d    = 1'b1;
          if (type_q == TYPE_READ) rsp_data_d = io;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          cnt_d   = 8'd0;
          cle_d   = 1'b0;
          ale_d   = 1'b0;
          drive_d = 1'b0;
          if (wait_q) begin
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
            if (last_q) ce_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        if (cnt_q == WB_LAST) begin
          state_d = S_WAIT_RB;
          cnt_d   = 8'd0;
`ifdef NAND_RB_TIMEOUT_EN
          tmo_d   = 24'd0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_RB: begin
        if (rb_s) begin
          state_d = S_IDLE;
          if (last_q) ce_d = 1'b1;
        end
`ifdef NAND_RB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_TIMEOUT;
          ce_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and pin registers; reset parks the bus in its idle, deselected state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      type_q     <= 2'b00;
      last_q     <= 1'b0;
      wait_q     <= 1'b0;
      ce_q       <= 1'b1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      we_q       <= 1'b1;
      re_q       <= 1'b1;
      drive_q    <= 1'b0;
      io_write_q <= 8'd0;
      rsp_data_q <= 8'd0;
`ifdef NAND_RB_TIMEOUT_EN
      tmo_q      <= 24'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      ce_q       <= ce_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      we_q       <= we_d;
      re_q       <= re_d;
      drive_q    <= drive_d;
      io_write_q <= io_write_d;
      rsp_data_q <= rsp_data_d;
`ifdef NAND_RB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign req_ready   = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_HIGH) && (cnt_q == HIGH_LAST) && (type_q == TYPE_READ);
  assign rsp_data    = rsp_data_q;
  assign ce          = ce_q;
  assign cle         = cle_q;
  assign ale         = ale_q;
  assign we          = we_q;
  assign re          = re_q;
  assign io_write    = io_write_q;
  assign io_drive_en = drive_q;

`ifdef NAND_RB_TIMEOUT_EN
  assign rb_timeout = (state_q == S_TIMEOUT);
`else
  assign rb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nand_bus_cycle.sv
// Bench for nand_bus_cycle: vector table, hand sequences and random requests
// checked against per-cycle waveforms derived from the timing rules.
module tb_nand_bus_cycle;

  localparam int TL = 2;
  localparam int TH = 2;
  localparam int TW = 4;
`ifdef NAND_RB_TIMEOUT_EN
  localparam int RBT = 50;
`else
  localparam int RBT = 1000000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_type = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       req_last = 1'b0;
  logic       req_wait_rb = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       rb_timeout;
  logic       ce, cle, ale, we, re;
  logic [7:0] io_write;
  logic       io_drive_en;
  logic [7:0] io = 8'h00;
  logic       rb = 1'b1;

  nand_bus_cycle #(.T_LOW(TL), .T_HIGH(TH), .T_WB(TW), .RB_TIMEOUT(RBT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_data(req_data), .req_last(req_last),
    .req_wait_rb(req_wait_rb), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .rb_timeout(rb_timeout), .ce(ce), .cle(cle), .ale(ale),
    .we(we), .re(re), .io_write(io_write), .io_drive_en(io_drive_en),
    .io(io), .rb(rb)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] t;
    logic [7:0] d;
    logic       l;
    logic       w;
    int         rise;
    logic [7:0] iov;
    int         exp_busy;
    logic       exp_ce;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // {ce,cle,ale,we,re,io_drive_en,busy,req_ready,rsp_valid}
  function automatic logic [8:0] pins();
    return {ce, cle, ale, we, re, io_drive_en, busy, req_ready, rsp_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request and check every cycle until the engine is idle again.
  task automatic run_req(input vec_t v, input string tag);
    logic [8:0] e;
    logic       low, strobe, rd;
    rd = (v.t == 2'b11);
    chk({tag, " ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_type = v.t; req_data = v.d;
    req_last = v.l; req_wait_rb = v.w;
    io = ~v.iov;
    if (v.w) rb = 1'b0;
    step();
    req_valid = 1'b0; req_data = ~v.d; req_type = 2'($urandom);
    for (int k = 0; k < v.exp_busy; k++) begin
      low    = (k < TL);
      strobe = (k < TL + TH);
      if (strobe)
        e = {1'b0, v.t == 2'b00, v.t == 2'b01, !(!rd && low), !(rd && low), !rd,
             1'b1, 1'b0, rd && (k == TL + TH - 1)};
      else
        e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      chk($sformatf("%s pins k=%0d", tag, k), pins(), e);
      if (strobe && !rd) chk($sformatf("%s io_write k=%0d", tag, k), io_write, v.d);
      if (rd && k == TL + TH - 1) chk({tag, " rsp_data"}, rsp_data, v.iov);
      io = (k == TL - 1) ? v.iov : ~v.iov;
      if (v.w && k + 1 >= v.rise) rb = 1'b1;
      step();
    end
    chk({tag, " idle_pins"}, pins(), {v.exp_ce, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    chk({tag, " rb_timeout"}, rb_timeout, 0);
    rb = 1'b1;
  endtask

  initial begin
    vec_t v;
    int   gap, pulses, pulse_k, busy_n;

    tbl[0] = '{2'b00, 8'h70, 1'b0, 1'b0, 0,  8'h00, 4,  1'b0};
    tbl[1] = '{2'b11, 8'h00, 1'b1, 1'b0, 0,  8'hA5, 4,  1'b1};
    tbl[2] = '{2'b10, 8'h3C, 1'b1, 1'b1, 20, 8'h00, 22, 1'b1};
    tbl[3] = '{2'b01, 8'h00, 1'b0, 1'b0, 0,  8'h00, 4,  1'b0};
    tbl[4] = '{2'b01, 8'h01, 1'b0, 1'b0, 0,  8'h00, 4,  1'b0};
    tbl[5] = '{2'b01, 8'h02, 1'b1, 1'b0, 0,  8'h00, 4,  1'b1};
    tbl[6] = '{2'b11, 8'h00, 1'b0, 1'b1, 3,  8'h5A, 9,  1'b0};
    tbl[7] = '{2'b10, 8'hFF, 1'b1, 1'b0, 0,  8'h00, 4,  1'b1};

    // Reset state
    step(); step();
    chk("reset pins", pins(), 9'b1_0_0_1_1_0_0_0_0);
    chk("reset io_write", io_write, 8'h00);
    chk("reset rsp_data", rsp_data, 8'h00);
    chk("reset rb_timeout", rb_timeout, 0);
    rst = 1'b0;
    step();
    chk("post_reset pins", pins(), 9'b1_0_0_1_1_0_0_1_0);

    // Reset in the middle of a WRITE low phase
    req_valid = 1'b1; req_type = 2'b10; req_data = 8'hAA; req_last = 1'b0; req_wait_rb = 1'b0;
    step();
    req_valid = 1'b0;
    chk("midrst low_pins", pins(), 9'b0_0_0_0_1_1_1_0_0);
    rst = 1'b1;
    step();
    chk("midrst pins", pins(), 9'b1_0_0_1_1_0_0_0_0);
    chk("midrst io_write", io_write, 8'h00);
    rst = 1'b0;
    step();
    chk("midrst ready", req_ready, 1);

    // Vector table
    for (int i = 0; i < 8; i++) run_req(tbl[i], $sformatf("vec%0d", i));

    // Random requests with random idle gaps
    for (int i = 0; i < 40; i++) begin
      v.t = 2'($urandom_range(0, 3));
      v.d = 8'($urandom);
      v.l = ($urandom_range(0, 2) == 0);
      v.w = ($urandom_range(0, 3) == 0);
      v.rise = $urandom_range(1, 30);
      v.iov = 8'($urandom);
      v.exp_busy = v.w ? ((v.rise + 2 > TL + TH + TW + 1) ? v.rise + 2 : TL + TH + TW + 1)
                       : TL + TH;
      v.exp_ce = v.l;
      run_req(v, $sformatf("rnd%0d", i));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk($sformatf("rnd%0d gap_ce", i), ce, v.exp_ce);
      end
    end

    // R/B stuck low
    req_valid = 1'b1; req_type = 2'b10; req_data = 8'h11; req_last = 1'b0; req_wait_rb = 1'b1;
    rb = 1'b0;
    step();
    req_valid = 1'b0;
    pulses = 0; pulse_k = -1; busy_n = 0;
    for (int k = 0; k < 70; k++) begin
      if (rb_timeout) begin
        pulses++;
        pulse_k = k;
      end
      if (busy) busy_n++;
      step();
    end
`ifdef NAND_RB_TIMEOUT_EN
    chk("tmo pulses", pulses, 1);
    chk("tmo pulse_cycle", pulse_k, TL + TH + TW + RBT);
    chk("tmo idle_busy", busy, 0);
    chk("tmo idle_ce", ce, 1);
`else
    chk("stuck pulses", pulses, 0);
    chk("stuck busy_cycles", busy_n, 70);
    chk("stuck ce", ce, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
    rb = 1'b1;
    step();
    chk("final ready", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
